// File: rtl/ex_mem_pipe.sv
// Elastic EX->MEM pipeline register: 2-slot skid buffer with valid/ready and synchronous flush.
// Optional performance counters are enabled by defining EX_MEM_PIPE_PERF_EN.
module ex_mem_pipe #(
    parameter int          DW       = 32,
    parameter int          PCW      = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    instrE,
    input  logic [DW-1:0]    ALUOutE,
    input  logic [DW-1:0]    WriteDataE,
    input  logic [PCW-1:0]   pcplusE,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    instrM,
    output logic [DW-1:0]    ALUOutM,
    output logic [DW-1:0]    WriteDataM,
    output logic [PCW-1:0]   pcplusM,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic           m_valid_reg, s_valid_reg;
    logic [DW-1:0]  m_instr_reg, m_alu_reg, m_wd_reg;
    logic [DW-1:0]  s_instr_reg, s_alu_reg, s_wd_reg;
    logic [PCW-1:0] m_pc_reg, s_pc_reg;
    logic           accept, drain;

    // in_ready comes straight from a flop, so MEM back-pressure never reaches EX combinationally.
    assign in_ready   = ~s_valid_reg;
    assign out_valid  = m_valid_reg;
    assign instrM     = m_instr_reg;
    assign ALUOutM    = m_alu_reg;
    assign WriteDataM = m_wd_reg;
    assign pcplusM    = m_pc_reg;

    assign accept = in_valid & ~s_valid_reg & ~flush;
    assign drain  = m_valid_reg & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_instr_reg <= '0;
            m_alu_reg   <= '0;
            m_wd_reg    <= '0;
            m_pc_reg    <= PCW'(RESET_PC);
            s_instr_reg <= '0;
            s_alu_reg   <= '0;
            s_wd_reg    <= '0;
            s_pc_reg    <= '0;
        end else if (flush) begin
            // Bubble: instr = 0 is a NOP; pcplus is left untouched.
            m_valid_reg <= 1'b0;
            s_valid_reg <= 1'b0;
            m_instr_reg <= '0;
            m_alu_reg   <= '0;
            m_wd_reg    <= '0;
        end else if (!m_valid_reg || (drain && !s_valid_reg)) begin
            m_valid_reg <= accept;
            if (accept) begin
                m_instr_reg <= instrE;
                m_alu_reg   <= ALUOutE;
                m_wd_reg    <= WriteDataE;
                m_pc_reg    <= pcplusE;
            end
        end else if (drain) begin
            // S is valid here: shift it into M and refill S from the input.
            m_instr_reg <= s_instr_reg;
            m_alu_reg   <= s_alu_reg;
            m_wd_reg    <= s_wd_reg;
            m_pc_reg    <= s_pc_reg;
            s_valid_reg <= accept;
            if (accept) begin
                s_instr_reg <= instrE;
                s_alu_reg   <= ALUOutE;
                s_wd_reg    <= WriteDataE;
                s_pc_reg    <= pcplusE;
            end
        end else if (accept) begin
            s_valid_reg <= 1'b1;
            s_instr_reg <= instrE;
            s_alu_reg   <= ALUOutE;
            s_wd_reg    <= WriteDataE;
            s_pc_reg    <= pcplusE;
        end
    end

`ifdef EX_MEM_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (m_valid_reg && !out_ready && !flush && stall_cnt_reg != CNT_MAX)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            // Only flushes that actually kill something are counted.
            if (flush && (m_valid_reg || s_valid_reg) && flush_cnt_reg != CNT_MAX)
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
